ccr_unit: RTL
=============

Name: ccr_unit

Overview:
- Condition-code register directly downstream of the execute-stage ALU.
- Latches the ALU Zero/Negative/Carry outputs under per-flag update masks and applies explicit carry set/clear instructions.
- Keeps a small LIFO of saved flag sets for interrupt entry (save) and RTI (restore).
- Its registered flags feed branch resolution and the control unit.

Parameters:
- SHADOW_DEPTH, 2, number of saved flag sets (nested interrupt depth); legal range 1..8.

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ZeroFlag  in  1  ALU zero output
- NegativeFlag  in  1  ALU negative output
- CarryFlag  in  1  ALU carry output
- FlagUpdateMask  in  3  per-flag write enable {Z,N,C} = bits [2:0]
- SetCarry  in  1  SETC instruction
- ClearCarry  in  1  CLRC instruction
- Stall  in  1  freeze all state updates except reset
- IntSave  in  1  interrupt entry: push flags
- RtiRestore  in  1  RTI: pop flags
- Flags  out  3  registered {Z,N,C}
- ShadowCount  out  $clog2(SHADOW_DEPTH+1)  number of saved entries
- ShadowOverflow  out  1  one-cycle pulse: save dropped
- ShadowUnderflow  out  1  one-cycle pulse: restore on empty LIFO

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - Flags=3'b000, ShadowCount=0, ShadowOverflow=0, ShadowUnderflow=0.
  - LIFO contents are don't-care.
  - Reset overrides all other inputs, including an operation in flight.
- Stall=1: no state changes. Both pulse outputs are 0 that cycle. Flags, LIFO and count hold.
- Per-cycle priority when not stalled:
  - Restore first. Else flag update. Then save.
- Restore (RtiRestore=1):
  - If ShadowCount>0: Flags<=LIFO[top] and ShadowCount decrements. The ALU masks, SetCarry and ClearCarry are ignored this cycle.
  - If ShadowCount==0: Flags follow the normal update path and ShadowUnderflow=1 for one cycle.
- Flag update (no successful restore):
  - Nxt[i] = FlagUpdateMask[i] ? ALU flag i : Flags[i].
  - SetCarry forces Nxt.C=1. ClearCarry forces Nxt.C=0.
  - If both are asserted, SetCarry wins.
  - Flags<=Nxt.
- Save (IntSave=1, no successful restore):
  - Pushes Nxt, i.e. the value including the concurrent update, because the instruction in execute retires before the interrupt.
  - If ShadowCount==SHADOW_DEPTH: push dropped, LIFO unchanged, ShadowOverflow=1 for one cycle.
- IntSave and RtiRestore together:
  - Restore wins; the save is dropped.
  - ShadowOverflow pulses, signalling a lost save.
- Latency:
  - Flags reflect inputs one cycle after the edge.
  - A push followed by a pop on the next cycle returns the pushed value.
- Pulse outputs are registered and are 0 on any cycle without their cause.

Optional Feature:
- Macro CCR_BRANCH_EVAL_EN.
- When defined, two ports are added:
  - BranchCond in 2: 00=JZ, 01=JN, 10=JC, 11=JMP.
  - BranchEval in 1.
- BranchTaken (out 1) is combinational from the registered Flags: Z, N, C or 1 per BranchCond, gated by BranchEval.
- On a taken conditional branch (not JMP) with Stall=0, the tested flag is cleared on the same edge. The clear is applied after SetCarry/ClearCarry and before the push.
- A successful restore overrides the clear.
- When not defined: no extra ports or logic; behaviour is exactly as above.

Decomposition:
- Package ccr_pkg holds:
  - flag bit indices FLAG_Z=2, FLAG_N=1, FLAG_C=0
  - a 3-bit flags_t typedef
  - BranchCond encodings
- One sub-module, ccr_shadow_lifo: parameterised LIFO with push, pop, count, full and empty. ccr_unit owns priority and pulse generation.

Test Plan:
- Reset then mask 3'b111 with ALU Z=1,N=0,C=1 -> Flags=3'b101 next cycle. Mask 3'b010 with N=1 -> Flags=3'b111.
- SetCarry and ClearCarry both set with Flags=3'b100 -> Flags=3'b101. ClearCarry alone -> 3'b100. Stall=1 with mask 3'b111 -> Flags unchanged.
- SHADOW_DEPTH=2: IntSave with Flags 3'b001, then 3'b110, then a third save -> ShadowCount=2 and ShadowOverflow pulses once. Two restores -> Flags=3'b110 then 3'b001, count=0.
- Restore on empty LIFO with mask 3'b100, Z=1 -> ShadowUnderflow pulse, Flags.Z=1, count stays 0.
- IntSave and RtiRestore together with count=1, top=3'b011 -> Flags=3'b011, count=0, ShadowOverflow pulse.
- With CCR_BRANCH_EVAL_EN: Flags=3'b100, BranchCond=00, BranchEval=1 -> BranchTaken=1 and Flags=3'b000 next cycle. BranchCond=11 -> taken, Flags unchanged. Also apply rst mid-sequence with count=2 -> count=0 and Flags=0.

Source files
------------

// File: rtl/ccr_pkg.sv
// ---------------------------------------------------------------------------
// ccr_pkg
// Shared definitions for the condition-code register block:
//   - bit positions of the Z/N/C flags inside a packed flag set
//   - flags_t, the 3-bit flag set type {Z,N,C}
//   - branch condition encodings used by the optional branch evaluator
//   - flag_update(), the masked ALU update with SETC/CLRC overrides
// ---------------------------------------------------------------------------
package ccr_pkg;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef logic [2:0] flags_t;

    typedef enum logic [1:0] {
        BR_JZ  = 2'b00,
        BR_JN  = 2'b01,
        BR_JC  = 2'b10,
        BR_JMP = 2'b11
    } br_cond_e;

    // Masked ALU update; SetCarry wins over ClearCarry when both are asserted.
    function automatic flags_t flag_update(
        input flags_t cur,
        input flags_t alu,
        input flags_t mask,
        input logic   set_c,
        input logic   clr_c
    );
        flags_t nxt;
        nxt = (mask & alu) | (~mask & cur);
        if (set_c) begin
            nxt[FLAG_C] = 1'b1;
        end else if (clr_c) begin
            nxt[FLAG_C] = 1'b0;
        end else begin
            nxt[FLAG_C] = nxt[FLAG_C];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ccr_shadow_lifo.sv
// ---------------------------------------------------------------------------
// ccr_shadow_lifo
// Small LIFO holding saved flag sets for nested interrupts.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (clears count only)
//   i_push, i_din - push a flag set (ignored when full)
//   i_pop         - pop the top entry (ignored when empty)
//   o_top         - current top entry (meaningless when empty)
//   o_count       - number of stored entries, 0..DEPTH
//   o_full/o_empty- occupancy status
// Push and pop are never requested together by ccr_unit; if they were,
// the push would take precedence.
// ---------------------------------------------------------------------------
module ccr_shadow_lifo
    import ccr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  flags_t                       i_din,
    output flags_t                       o_top,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flags_t             r_mem [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    assign o_count  = r_count;
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == {CNT_W{1'b0}});
    assign w_wr_idx = IDX_W'(r_count);
    // Keep the read index in range when empty so o_top never reads past the array.
    assign w_rd_idx = o_empty ? {IDX_W{1'b0}} : IDX_W'(r_count - CNT_W'(1));
    assign o_top    = r_mem[w_rd_idx];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_push && !o_full) begin
            r_count <= r_count + CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ccr_unit.sv
// ---------------------------------------------------------------------------
// ccr_unit
// Condition-code register following the execute-stage ALU. Latches ALU
// Z/N/C under per-flag masks, applies SETC/CLRC, and saves/restores flag
// sets through a small LIFO on interrupt entry / RTI.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   ZeroFlag/NegativeFlag/CarryFlag - ALU flag outputs
//   FlagUpdateMask[2:0] - per-flag write enable {Z,N,C}
//   SetCarry/ClearCarry - SETC / CLRC (SetCarry wins)
//   Stall               - freeze all state
//   IntSave/RtiRestore  - push / pop the flag LIFO
//   Flags[2:0]          - registered {Z,N,C}
//   ShadowCount         - saved entries
//   ShadowOverflow      - one-cycle pulse, a save was dropped
//   ShadowUnderflow     - one-cycle pulse, restore on empty LIFO
// Optional feature, macro CCR_BRANCH_EVAL_EN:
//   BranchCond[1:0], BranchEval in; BranchTaken out (combinational from
//   Flags). A taken conditional branch clears the flag it tested.
// Per-cycle priority: successful restore, else flag update, then save.
// ---------------------------------------------------------------------------
module ccr_unit
    import ccr_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ZeroFlag,
    input  logic                                 NegativeFlag,
    input  logic                                 CarryFlag,
    input  logic [2:0]                           FlagUpdateMask,
    input  logic                                 SetCarry,
    input  logic                                 ClearCarry,
    input  logic                                 Stall,
    input  logic                                 IntSave,
    input  logic                                 RtiRestore,
`ifdef CCR_BRANCH_EVAL_EN
    input  logic [1:0]                           BranchCond,
    input  logic                                 BranchEval,
    output logic                                 BranchTaken,
`endif
    output logic [2:0]                           Flags,
    output logic [$clog2(SHADOW_DEPTH+1)-1:0]    ShadowCount,
    output logic                                 ShadowOverflow,
    output logic                                 ShadowUnderflow
);

    flags_t r_flags;
    logic   r_ovf;
    logic   r_unf;

    flags_t w_alu;
    flags_t w_upd;
    flags_t w_nxt;
    flags_t w_flags_d;
    flags_t w_br_clr_mask;
    flags_t w_lifo_top;
    logic   w_lifo_full;
    logic   w_lifo_empty;
    logic   w_restore_ok;
    logic   w_push;
    logic   w_pop;
    logic   w_ovf_d;
    logic   w_unf_d;

    assign w_alu = {ZeroFlag, NegativeFlag, CarryFlag};
    assign w_upd = flag_update(r_flags, w_alu, flags_t'(FlagUpdateMask), SetCarry, ClearCarry);

`ifdef CCR_BRANCH_EVAL_EN
    logic w_br_sel;
    logic w_br_cond;
    logic w_br_taken;

    // Decode the tested flag and whether the branch is conditional.
    always_comb begin
        w_br_sel      = 1'b0;
        w_br_cond     = 1'b0;
        w_br_clr_mask = 3'b000;
        case (br_cond_e'(BranchCond))
            BR_JZ: begin
                w_br_sel      = r_flags[FLAG_Z];
                w_br_cond     = 1'b1;
                w_br_clr_mask = 3'b100;
            end
            BR_JN: begin
                w_br_sel      = r_flags[FLAG_N];
                w_br_cond     = 1'b1;
                w_br_clr_mask = 3'b010;
            end
            BR_JC: begin
                w_br_sel      = r_flags[FLAG_C];
                w_br_cond     = 1'b1;
                w_br_clr_mask = 3'b001;
            end
            BR_JMP: begin
                w_br_sel      = 1'b1;
                w_br_cond     = 1'b0;
                w_br_clr_mask = 3'b000;
            end
            default: begin
                w_br_sel      = 1'b0;
                w_br_cond     = 1'b0;
                w_br_clr_mask = 3'b000;
            end
        endcase
    end

    assign w_br_taken  = BranchEval & w_br_sel;
    assign BranchTaken = w_br_taken;

    // The tested flag is consumed by a taken conditional branch, after SETC/CLRC.
    always_comb begin
        w_nxt = w_upd;
        if (w_br_taken && w_br_cond && !Stall) begin
            w_nxt = w_upd & ~w_br_clr_mask;
        end else begin
            w_nxt = w_upd;
        end
    end
`else
    assign w_br_clr_mask = 3'b000;
    assign w_nxt         = w_upd & ~w_br_clr_mask;
`endif

    ccr_shadow_lifo #(
        .DEPTH   (SHADOW_DEPTH)
    ) u_lifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_nxt),
        .o_top   (w_lifo_top),
        .o_count (ShadowCount),
        .o_full  (w_lifo_full),
        .o_empty (w_lifo_empty)
    );

    // Restore/update/save arbitration and pulse causes.
    always_comb begin
        w_restore_ok = RtiRestore & ~w_lifo_empty;
        w_pop        = ~Stall & w_restore_ok;
        // The pushed value includes this cycle's update: the executing
        // instruction retires before the interrupt is taken.
        w_push       = ~Stall & IntSave & ~w_restore_ok & ~w_lifo_full;
        // A save is lost either to a full LIFO or to a concurrent restore.
        w_ovf_d      = ~Stall & IntSave & (w_restore_ok | w_lifo_full);
        w_unf_d      = ~Stall & RtiRestore & w_lifo_empty;
        if (w_restore_ok) begin
            w_flags_d = w_lifo_top;
        end else begin
            w_flags_d = w_nxt;
        end
    end

    // Flag register and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 3'b000;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_ovf <= w_ovf_d;
            r_unf <= w_unf_d;
            if (!Stall) begin
                r_flags <= w_flags_d;
            end
        end
    end

    assign Flags           = r_flags;
    assign ShadowOverflow  = r_ovf;
    assign ShadowUnderflow = r_unf;

endmodule
